// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, per-transfer configuration and parameter defaults.
// Imported by both the SPI master and the SPI slave.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_first;
    } spi_cfg_t;

    localparam int SPI_WIDTH_DEF   = 8;
    localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_clk_tick.sv
// Half-period timer: emits a one-cycle tick every CLK_DIV clocks while enabled.
// The count restarts from zero whenever the enable is low.
module spi_clk_tick
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Byte-oriented SPI master: serialises data_in on mosi while assembling miso into data_out.
// Mode and bit order are latched on the accepted start and held for the whole transfer.
module spi_master
    import spi_pkg::*;
#(
    parameter int WIDTH   = SPI_WIDTH_DEF,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             msb_first,
    input  logic             miso,
    output logic             sck,
    output logic             cs,
    output logic             mosi,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             end_of_byte
);

    localparam int EDGES = 2 * WIDTH;
    localparam int EW    = $clog2(EDGES + 1);

    spi_state_t       state, state_nxt;
    spi_cfg_t         cfg;
    logic             tick;
    logic [EW-1:0]    edge_cnt;
    logic [EW-1:0]    edge_num;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic             edge_go;
    logic             lead_edge;
    logic             samp_edge;
    logic             shift_edge;
    logic             last_edge;

    function automatic logic first_bit(input logic [WIDTH-1:0] v, input logic msb);
        return msb ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v, input logic msb);
        return msb ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] v, input logic b,
                                                  input logic msb);
        return msb ? {v[WIDTH-2:0], b} : {b, v[WIDTH-1:1]};
    endfunction

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .tick (tick)
    );

    // Edge 1 is produced by the tick that ends LEAD; odd edges are leading edges.
    assign edge_go    = tick && (state == LEAD || state == XFER);
    assign edge_num   = edge_cnt + EW'(1);
    assign lead_edge  = edge_num[0];
    assign last_edge  = (edge_num == EW'(EDGES));
    assign samp_edge  = edge_go && (lead_edge != cfg.cpha);
    assign shift_edge = edge_go && (lead_edge == cfg.cpha) && !last_edge;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = LEAD;
            LEAD:    if (tick) state_nxt = XFER;
            XFER:    if (tick && last_edge) state_nxt = TRAIL;
            TRAIL:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg         <= '0;
            edge_cnt    <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            sck         <= 1'b0;
            cs          <= 1'b1;
            mosi        <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            end_of_byte <= 1'b0;
        end else begin
            end_of_byte <= 1'b0;
            unique case (state)
                IDLE: begin
                    sck <= cpol;
                    if (start) begin
                        cfg      <= {cpol, cpha, msb_first};
                        cs       <= 1'b0;
                        busy     <= 1'b1;
                        edge_cnt <= '0;
                        // With cpha=0 the first bit must already be valid at the cs fall.
                        if (!cpha) begin
                            mosi  <= first_bit(data_in, msb_first);
                            tx_sr <= shift_out(data_in, msb_first);
                        end else begin
                            tx_sr <= data_in;
                        end
                    end
                end
                LEAD, XFER: begin
                    if (edge_go) begin
                        sck      <= ~sck;
                        edge_cnt <= edge_num;
                        if (samp_edge) begin
                            rx_sr <= shift_in(rx_sr, miso, cfg.msb_first);
                        end
                        if (shift_edge) begin
                            mosi  <= first_bit(tx_sr, cfg.msb_first);
                            tx_sr <= shift_out(tx_sr, cfg.msb_first);
                        end
                    end
                end
                TRAIL: begin
                    sck <= cfg.cpol;
                    if (tick) begin
                        cs          <= 1'b1;
                        busy        <= 1'b0;
                        data_out    <= rx_sr;
                        end_of_byte <= 1'b1;
                        edge_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
